// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types and defaults for the pipeline hazard/forwarding controller.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned NREG_DEF   = 32;
  localparam int unsigned REG_ZERO   = 0;

  typedef enum logic [1:0] {
    FWD_IDEX = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_mdu_scoreboard.sv
// Tracks the single in-flight MDU op: countdown, destination, done pulse,
// and the RAW/WAW/structural compares against the instruction in ID.
module mdu_scoreboard
  import pipe_pkg::*;
#(
  parameter  int unsigned NREG    = NREG_DEF,
  parameter  int unsigned MDU_LAT = 4,
  localparam int unsigned REG_AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_regwrite,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_is_mdu,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic [REG_AW-1:0] mdu_dst,
  output logic              raw_hazard,
  output logic              waw_hazard,
  output logic              struct_hazard
);

  localparam int unsigned CNT_W = $clog2(MDU_LAT + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [REG_AW-1:0] dst_q, dst_d;

  assign mdu_busy = busy_q;
  assign mdu_dst  = dst_q;
  assign mdu_done = busy_q && (cnt_q == CNT_W'(1));

  always_comb begin
    raw_hazard    = id_valid && busy_q && (dst_q != REG_AW'(REG_ZERO)) &&
                    ((id_rs_used && id_rs == dst_q) || (id_rt_used && id_rt == dst_q));
    waw_hazard    = id_valid && busy_q && id_regwrite && (id_dst == dst_q);
    struct_hazard = id_valid && busy_q && id_is_mdu && !mdu_done;
  end

  // A new issue in the done cycle wins over the clear, giving back-to-back ops.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    dst_d  = dst_q;
    if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (mdu_done) busy_d = 1'b0;
    end
    if (issue) begin
      cnt_d  = CNT_W'(MDU_LAT);
      dst_d  = id_dst;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      dst_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      dst_q  <= dst_d;
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and flush controller for the 5-stage pipeline.
// Define HAZARD_STATS_EN to add saturating 32-bit event counters.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter  int unsigned DATA_W  = DATA_W_DEF,
  parameter  int unsigned NREG    = NREG_DEF,
  parameter  int unsigned MDU_LAT = 4,
  localparam int unsigned REG_AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_regwrite,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_is_mdu,
  input  logic              id_jump,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [DATA_W-1:0] ex_rd1,
  input  logic [DATA_W-1:0] ex_rd2,
  input  logic              ex_branch_taken,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic [DATA_W-1:0] mem_aluout,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic [DATA_W-1:0] wb_wd,
  output logic              stall,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic [DATA_W-1:0] fwd_a,
  output logic [DATA_W-1:0] fwd_b,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic [REG_AW-1:0] mdu_dst
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stat_stall_cycles,
  output logic [31:0]       stat_loaduse,
  output logic [31:0]       stat_mdu_stall,
  output logic [31:0]       stat_flushes
`endif
);

  localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(REG_ZERO);

  fwd_sel_e sel_a, sel_b;
  logic     load_use, mdu_hazard, issue;
  logic     raw_hazard, waw_hazard, struct_hazard;

  // ex_regwrite is implied by ex_memread for loads; kept for interface parity.
  logic unused_ex_regwrite;
  assign unused_ex_regwrite = ex_regwrite;

  always_comb begin
    sel_a = FWD_IDEX;
    if (mem_regwrite && mem_dst != ZERO_REG && mem_dst == ex_rs)   sel_a = FWD_MEM;
    else if (wb_regwrite && wb_dst != ZERO_REG && wb_dst == ex_rs) sel_a = FWD_WB;
    sel_b = FWD_IDEX;
    if (mem_regwrite && mem_dst != ZERO_REG && mem_dst == ex_rt)   sel_b = FWD_MEM;
    else if (wb_regwrite && wb_dst != ZERO_REG && wb_dst == ex_rt) sel_b = FWD_WB;
  end

  always_comb begin
    case (sel_a)
      FWD_MEM: fwd_a = mem_aluout;
      FWD_WB:  fwd_a = wb_wd;
      default: fwd_a = ex_rd1;
    endcase
    case (sel_b)
      FWD_MEM: fwd_b = mem_aluout;
      FWD_WB:  fwd_b = wb_wd;
      default: fwd_b = ex_rd2;
    endcase
  end

  assign fwd_sel_a = sel_a;
  assign fwd_sel_b = sel_b;

  always_comb begin
    load_use   = id_valid && ex_valid && ex_memread && (ex_dst != ZERO_REG) &&
                 ((id_rs_used && id_rs == ex_dst) || (id_rt_used && id_rt == ex_dst));
    mdu_hazard = raw_hazard || waw_hazard || struct_hazard;
    stall      = (load_use || mdu_hazard) && !ex_branch_taken;
    flush_ifid = ex_branch_taken || (id_jump && !stall);
    flush_idex = ex_branch_taken || stall;
    issue      = id_valid && id_is_mdu && !stall && !ex_branch_taken;
  end

  mdu_scoreboard #(
    .NREG    (NREG),
    .MDU_LAT (MDU_LAT)
  ) u_mdu_sb (
    .clk           (clk),
    .reset         (reset),
    .issue         (issue),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rs_used    (id_rs_used),
    .id_rt_used    (id_rt_used),
    .id_regwrite   (id_regwrite),
    .id_dst        (id_dst),
    .id_is_mdu     (id_is_mdu),
    .mdu_busy      (mdu_busy),
    .mdu_done      (mdu_done),
    .mdu_dst       (mdu_dst),
    .raw_hazard    (raw_hazard),
    .waw_hazard    (waw_hazard),
    .struct_hazard (struct_hazard)
  );

`ifdef HAZARD_STATS_EN
  logic [31:0] stat_stall_q, stat_stall_d;
  logic [31:0] stat_lu_q, stat_lu_d;
  logic [31:0] stat_mdu_q, stat_mdu_d;
  logic [31:0] stat_fl_q, stat_fl_d;

  always_comb begin
    stat_stall_d = stall                    ? sat_inc(stat_stall_q) : stat_stall_q;
    stat_lu_d    = load_use                 ? sat_inc(stat_lu_q)    : stat_lu_q;
    stat_mdu_d   = mdu_hazard               ? sat_inc(stat_mdu_q)   : stat_mdu_q;
    stat_fl_d    = (flush_ifid||flush_idex) ? sat_inc(stat_fl_q)    : stat_fl_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stall_q <= '0;
      stat_lu_q    <= '0;
      stat_mdu_q   <= '0;
      stat_fl_q    <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_lu_q    <= stat_lu_d;
      stat_mdu_q   <= stat_mdu_d;
      stat_fl_q    <= stat_fl_d;
    end
  end

  assign stat_stall_cycles = stat_stall_q;
  assign stat_loaduse      = stat_lu_q;
  assign stat_mdu_stall    = stat_mdu_q;
  assign stat_flushes      = stat_fl_q;
`endif

endmodule
